// File: rtl/salyut1_rst_pkg.sv
// salyut1_rst_pkg -- shared state encoding and rst_cause bit positions.
// Rev 1.0
`default_nettype none

package salyut1_rst_pkg;

  typedef enum logic [1:0] {
    POR  = 2'd0,
    IDLE = 2'd1,
    FULL = 2'd2,
    CPU  = 2'd3
  } rst_state_e;

  localparam int CAUSE_W   = 3;
  localparam int CAUSE_POR = 0;
  localparam int CAUSE_BTN = 1;
  localparam int CAUSE_SW  = 2;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

`default_nettype wire

// File: rtl/salyut1_debounce.sv
// salyut1_debounce -- 2-flop synchroniser plus counter debouncer for an active-low button.
// Rev 1.0
`default_nettype none

module salyut1_debounce #(
  parameter int DEBOUNCE_CYCLES = 65536
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din_n,
  output logic dout,
  output logic fall_pulse
);

  localparam int              DW      = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam logic [DW-1:0]   DB_LAST = DW'(DEBOUNCE_CYCLES - 1);

  logic          sync1_q;
  logic          sync2_q;
  logic          db_q;
  logic          fall_q;
  logic [DW-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      db_q    <= 1'b1;
      fall_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= din_n;
      sync2_q <= sync1_q;
      fall_q  <= 1'b0;
      // Any cycle agreeing with the accepted level restarts the stability window.
      if (sync2_q == db_q) begin
        cnt_q <= '0;
      end else if (cnt_q >= DB_LAST) begin
        db_q   <= sync2_q;
        cnt_q  <= '0;
        fall_q <= db_q;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  assign dout       = db_q;
  assign fall_pulse = fall_q;

endmodule

`default_nettype wire

// File: rtl/salyut1_reset_req.sv
// salyut1_reset_req -- merges POR, button and software requests into full/CPU reset pulses.
// Rev 1.0
`default_nettype none

module salyut1_reset_req
  import salyut1_rst_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 65536,
  parameter int FULL_PULSE      = 64,
  parameter int CPU_PULSE       = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               btn_rst_n,
  input  logic               sw_full_req,
  input  logic               sw_cpu_req,
  input  logic               cpu_hold,
  input  logic               cause_clr,
  output logic               full_rst,
  output logic               cpu_rst,
  output logic               rst_busy,
  output logic [CAUSE_W-1:0] rst_cause
);

  localparam int            MAXP      = max_int(FULL_PULSE, CPU_PULSE);
  localparam int            CW        = $clog2(MAXP) + 1;
  localparam logic [CW-1:0] FULL_LAST = CW'(FULL_PULSE - 1);
  localparam logic [CW-1:0] CPU_LAST  = CW'(CPU_PULSE - 1);

  rst_state_e         state_q;
  logic [CW-1:0]      cnt_q;
  logic [CW-1:0]      cnt_inc;
  logic               full_q;
  logic               cpu_q;
  logic               busy_q;
  logic [CAUSE_W-1:0] cause_q;
  logic [CAUSE_W-1:0] cause_d;
  logic               btn_db;
  logic               press;
  logic               full_req;
  logic               enter_full;

  salyut1_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_debounce (
    .clk       (clk),
    .rst_n     (rst_n),
    .din_n     (btn_rst_n),
    .dout      (btn_db),
    .fall_pulse(press)
  );

  assign full_req   = press | sw_full_req;
  assign enter_full = full_req & ((state_q == IDLE) | (state_q == CPU));
  assign cnt_inc    = (&cnt_q) ? cnt_q : cnt_q + 1'b1;

  // Set is applied after clear so a same-cycle source wins.
  always_comb begin
    cause_d = cause_q;
    if (cause_clr) cause_d = '0;
    if (enter_full && press)       cause_d[CAUSE_BTN] = 1'b1;
    if (enter_full && sw_full_req) cause_d[CAUSE_SW]  = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= POR;
      cnt_q   <= '0;
      full_q  <= 1'b1;
      cpu_q   <= 1'b0;
      busy_q  <= 1'b1;
      cause_q <= CAUSE_W'(1) << CAUSE_POR;
    end else begin
      cause_q <= cause_d;
      case (state_q)
        POR: begin
          if (cnt_q >= FULL_LAST) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            full_q  <= 1'b0;
            busy_q  <= 1'b0;
          end else begin
            cnt_q <= cnt_inc;
          end
        end
        IDLE: begin
          if (full_req) begin
            state_q <= FULL;
            cnt_q   <= '0;
            full_q  <= 1'b1;
            busy_q  <= 1'b1;
          end else if (sw_cpu_req || cpu_hold) begin
            state_q <= CPU;
            cnt_q   <= '0;
            cpu_q   <= 1'b1;
            busy_q  <= 1'b1;
          end
        end
        FULL: begin
          // A held button stretches the pulse until the debounced release.
          if (cnt_q >= FULL_LAST && btn_db) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            full_q  <= 1'b0;
            busy_q  <= 1'b0;
          end else begin
            cnt_q <= cnt_inc;
          end
        end
        CPU: begin
          if (full_req) begin
            state_q <= FULL;
            cnt_q   <= '0;
            full_q  <= 1'b1;
            cpu_q   <= 1'b0;
          end else if (cnt_q >= CPU_LAST && !cpu_hold) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            cpu_q   <= 1'b0;
            busy_q  <= 1'b0;
          end else begin
            cnt_q <= cnt_inc;
          end
        end
        default: begin
          state_q <= POR;
          cnt_q   <= '0;
          full_q  <= 1'b1;
          cpu_q   <= 1'b0;
          busy_q  <= 1'b1;
        end
      endcase
    end
  end

  assign full_rst  = full_q;
  assign cpu_rst   = cpu_q;
  assign rst_busy  = busy_q;
  assign rst_cause = cause_q;

endmodule

`default_nettype wire

// File: tb/tb_salyut1_reset_req.sv
// tb_salyut1_reset_req -- scoreboard bench for the reset request block.
// Rev 1.0
`default_nettype none

module tb_salyut1_reset_req;

  localparam int DEBOUNCE_CYCLES = 8;
  localparam int FULL_PULSE      = 16;
  localparam int CPU_PULSE       = 4;
  localparam int MEAS_LIMIT      = 200;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       btn_rst_n = 1'b1;
  logic       sw_full_req = 1'b0;
  logic       sw_cpu_req = 1'b0;
  logic       cpu_hold = 1'b0;
  logic       cause_clr = 1'b0;
  logic       full_rst;
  logic       cpu_rst;
  logic       rst_busy;
  logic [2:0] rst_cause;

  typedef struct {
    string tag;
    int    exp;
  } exp_t;

  exp_t sb_q[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   w;
  bit   oth;
  bit   ok;
  bit   mon_en = 1'b0;
  bit   prev_full = 1'b0;
  int   rises = 0;

  salyut1_reset_req #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .FULL_PULSE     (FULL_PULSE),
    .CPU_PULSE      (CPU_PULSE)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .btn_rst_n  (btn_rst_n),
    .sw_full_req(sw_full_req),
    .sw_cpu_req (sw_cpu_req),
    .cpu_hold   (cpu_hold),
    .cause_clr  (cause_clr),
    .full_rst   (full_rst),
    .cpu_rst    (cpu_rst),
    .rst_busy   (rst_busy),
    .rst_cause  (rst_cause)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (mon_en) begin
      if (full_rst && !prev_full) rises <= rises + 1;
      prev_full <= full_rst;
    end
  end

  task automatic check_val(input string tag, input int obs, input int exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic sb_push(input string tag, input int exp);
    exp_t e;
    e.tag = tag;
    e.exp = exp;
    sb_q.push_back(e);
  endtask

  task automatic sb_pop_check(input int obs);
    exp_t e;
    if (sb_q.size() == 0) begin
      check_val("sb_empty", 1, 0);
    end else begin
      e = sb_q.pop_front();
      check_val(e.tag, obs, e.exp);
    end
  endtask

  // Counts consecutive negedge samples with the selected output high, starting now.
  task automatic measure(input bit sel_cpu, output int width, output bit other_seen);
    width      = 0;
    other_seen = 1'b0;
    while ((sel_cpu ? cpu_rst : full_rst) === 1'b1) begin
      width++;
      if ((sel_cpu ? full_rst : cpu_rst) === 1'b1) other_seen = 1'b1;
      if (width >= MEAS_LIMIT) begin
        check_val("meas_timeout", width, 0);
        break;
      end
      @(negedge clk);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state while rst_n is held low.
    repeat (3) @(negedge clk);
    check_val("rst_full", full_rst, 1);
    check_val("rst_cpu", cpu_rst, 0);
    check_val("rst_busy", rst_busy, 1);
    check_val("rst_cause", rst_cause, 3'b001);

    // POR pulse after release.
    sb_push("por_width", FULL_PULSE);
    sb_push("por_busy_after", 0);
    sb_push("por_cause", 3'b001);
    rst_n = 1'b1;
    measure(1'b0, w, oth);
    sb_pop_check(w);
    sb_pop_check(rst_busy);
    sb_pop_check(rst_cause);
    repeat (2) @(negedge clk);

    // Bouncing button then a long press: one FULL entry, stretched until release.
    sb_push("btn_entries", 1);
    sb_push("btn_held_high", 1);
    sb_push("btn_tail_width", 2 + DEBOUNCE_CYCLES + 1);
    sb_push("btn_cause", 3'b011);
    prev_full = 1'b0;
    mon_en    = 1'b1;
    for (int i = 0; i < 40; i++) begin
      btn_rst_n = ((i / 3) % 2 == 0) ? 1'b0 : 1'b1;
      @(negedge clk);
    end
    btn_rst_n = 1'b0;
    repeat (30) @(negedge clk);
    sb_pop_check(rises);
    sb_pop_check(full_rst);
    btn_rst_n = 1'b1;
    measure(1'b0, w, oth);
    mon_en = 1'b0;
    sb_pop_check(w);
    sb_pop_check(rst_cause);
    repeat (2) @(negedge clk);

    // CPU reset stretched by cpu_hold, then a bare request.
    sb_push("cpu_hold_width", 20);
    sb_push("cpu_hold_full_seen", 0);
    sb_push("cpu_width", CPU_PULSE);
    sb_push("cpu_full_seen", 0);
    sb_push("cpu_busy_after", 0);
    sw_cpu_req = 1'b1;
    cpu_hold   = 1'b1;
    fork
      begin
        @(negedge clk);
        sw_cpu_req = 1'b0;
        repeat (19) @(negedge clk);
        cpu_hold = 1'b0;
      end
      begin
        @(negedge clk);
        measure(1'b1, w, oth);
      end
    join
    sb_pop_check(w);
    sb_pop_check(oth);
    repeat (2) @(negedge clk);
    sw_cpu_req = 1'b1;
    @(negedge clk);
    sw_cpu_req = 1'b0;
    measure(1'b1, w, oth);
    sb_pop_check(w);
    sb_pop_check(oth);
    sb_pop_check(rst_busy);
    repeat (2) @(negedge clk);

    // Software full request in the second CPU cycle pre-empts the CPU pulse.
    sb_push("pre_cpu_width", 2);
    sb_push("pre_handoff", 2'b01);
    sb_push("pre_full_width", FULL_PULSE);
    sb_push("pre_cause", 3'b111);
    sw_cpu_req = 1'b1;
    @(negedge clk);
    sw_cpu_req = 1'b0;
    w = 0;
    if (cpu_rst) w++;
    @(negedge clk);
    sw_full_req = 1'b1;
    if (cpu_rst) w++;
    @(negedge clk);
    sw_full_req = 1'b0;
    if (cpu_rst) w++;
    sb_pop_check(w);
    sb_pop_check({30'd0, cpu_rst, full_rst});
    measure(1'b0, w, oth);
    sb_pop_check(w);
    sb_pop_check(rst_cause);
    repeat (2) @(negedge clk);

    // Full beats CPU in the same cycle; CPU request inside FULL is dropped.
    sb_push("prio_full_width", FULL_PULSE);
    sb_push("prio_cpu_seen", 0);
    sb_push("prio_cpu_after", 0);
    sw_full_req = 1'b1;
    sw_cpu_req  = 1'b1;
    @(negedge clk);
    sw_full_req = 1'b0;
    sw_cpu_req  = 1'b0;
    fork
      measure(1'b0, w, oth);
      begin
        repeat (3) @(negedge clk);
        sw_cpu_req = 1'b1;
        @(negedge clk);
        sw_cpu_req = 1'b0;
      end
    join
    sb_pop_check(w);
    sb_pop_check(oth);
    ok = 1'b0;
    repeat (3) begin
      if (cpu_rst) ok = 1'b1;
      @(negedge clk);
    end
    sb_pop_check(ok);

    // Clear coinciding with a software full acceptance, then clear alone.
    sb_push("clr_set_width", FULL_PULSE);
    sb_push("clr_set_cause", 3'b100);
    sb_push("clr_only_cause", 3'b000);
    cause_clr   = 1'b1;
    sw_full_req = 1'b1;
    @(negedge clk);
    cause_clr   = 1'b0;
    sw_full_req = 1'b0;
    measure(1'b0, w, oth);
    sb_pop_check(w);
    sb_pop_check(rst_cause);
    cause_clr = 1'b1;
    @(negedge clk);
    cause_clr = 1'b0;
    sb_pop_check(rst_cause);
    repeat (2) @(negedge clk);

    // Power-on reset glitch in the middle of FULL.
    sb_push("glitch_pre_high", 1);
    sb_push("glitch_async_full", 1);
    sb_push("glitch_async_cause", 3'b001);
    sb_push("glitch_por_width", FULL_PULSE);
    sb_push("glitch_cause", 3'b001);
    sb_push("glitch_busy_after", 0);
    sw_full_req = 1'b1;
    @(negedge clk);
    sw_full_req = 1'b0;
    ok = 1'b1;
    repeat (5) begin
      if (!full_rst) ok = 1'b0;
      @(negedge clk);
    end
    sb_pop_check(ok);
    rst_n = 1'b0;
    #1;
    sb_pop_check(full_rst);
    sb_pop_check(rst_cause);
    @(negedge clk);
    rst_n = 1'b1;
    measure(1'b0, w, oth);
    sb_pop_check(w);
    sb_pop_check(rst_cause);
    sb_pop_check(rst_busy);

    check_val("sb_leftover", sb_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
